// File: rtl/ads_i2c_bit_engine.sv
// Byte-level I2C master for the ADS1115 link: START, STOP, WRITE and READ on open-drain
// SCL/SDA, paced by single-cycle ticks derived from the edges of mod_clk.
//
// state   | meaning
// S_IDLE  | no command in flight, cmd_ready high, lines hold their last level
// S_START | START or repeated START, four quarters
// S_WRITE | eight data bits out MSB first, then slave ACK sampled into nack
// S_READ  | eight data bits sampled MSB first, then master ACK/NACK driven
// S_STOP  | STOP condition, both lines released at the end
module ads_i2c_bit_engine #(
  parameter int unsigned TICKS_PER_QUARTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mod_clk,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       cmd_ready,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       nack,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [3:0] PRE_RELOAD = 4'(TICKS_PER_QUARTER - 1);
  localparam logic [3:0] LAST_BIT   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_STOP
  } state_t;

  state_t      state;
  logic        mod_clk_d;
  logic [3:0]  pre_cnt;
  logic [1:0]  quarter;
  logic [3:0]  bit_cnt;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic        ack_bit;

  logic        tick;
  logic        busy;
  logic        qtick;
  logic        step;
  logic        last_bit;
  logic        bit_sda;

  assign tick     = mod_clk ^ mod_clk_d;
  assign busy     = (state != S_IDLE);
  assign qtick    = tick && busy && (pre_cnt == 4'd0);
  // A slave holding SCL low during the sampling quarter freezes the sequence.
  assign step     = qtick && !((quarter == 2'd2) && !scl_in);
  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    bit_sda = 1'b0;
    if (state == S_WRITE) begin
      bit_sda = last_bit ? 1'b0 : ~tx_shift[7];
    end else if (state == S_READ) begin
      bit_sda = last_bit ? ack_bit : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_clk_d <= 1'b0;
    end else begin
      mod_clk_d <= mod_clk;
    end
  end

  // Quarter prescaler: down-counter reloaded while idle so a command starts on a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= 4'd0;
    end else if (!busy) begin
      pre_cnt <= PRE_RELOAD;
    end else if (tick) begin
      pre_cnt <= (pre_cnt == 4'd0) ? PRE_RELOAD : pre_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      rd_data   <= 8'h00;
      nack      <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      quarter   <= 2'd0;
      bit_cnt   <= 4'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      ack_bit   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            quarter   <= 2'd0;
            bit_cnt   <= 4'd0;
            tx_shift  <= wr_data;
            ack_bit   <= rd_ack;
            case (cmd)
              CMD_START: state <= S_START;
              CMD_WRITE: state <= S_WRITE;
              CMD_READ:  state <= S_READ;
              default:   state <= S_STOP;
            endcase
          end
        end

        S_START: begin
          if (step) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sda_oe <= 1'b0;
              2'd1: scl_oe <= 1'b0;
              2'd2: sda_oe <= 1'b1;
              default: begin
                scl_oe    <= 1'b1;
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
                done      <= 1'b1;
              end
            endcase
          end
        end

        S_STOP: begin
          if (step) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sda_oe <= 1'b1;
              2'd1: scl_oe <= 1'b0;
              2'd2: sda_oe <= 1'b0;
              default: begin
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
                done      <= 1'b1;
              end
            endcase
          end
        end

        S_WRITE, S_READ: begin
          if (step) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: sda_oe <= bit_sda;
              2'd1: scl_oe <= 1'b0;
              2'd2: begin
                if (!last_bit) begin
                  rx_shift <= {rx_shift[6:0], sda_in};
                end else if (state == S_WRITE) begin
                  nack <= sda_in;
                end
              end
              default: begin
                scl_oe <= 1'b1;
                if (last_bit) begin
                  bit_cnt   <= 4'd0;
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  done      <= 1'b1;
                  if (state == S_READ) begin
                    rd_data <= rx_shift;
                  end
                end else begin
                  bit_cnt  <= bit_cnt + 4'd1;
                  tx_shift <= {tx_shift[6:0], 1'b0};
                end
              end
            endcase
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads_i2c_bit_engine.sv
// Self-checking bench for ads_i2c_bit_engine: vector table, randomized byte traffic and
// hand-written corner sequences, all against a quarter-level model of the bus lines.
module tb_ads_i2c_bit_engine;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       mod_clk;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_ack;
  logic       cmd_ready;
  logic       done;
  logic [7:0] rd_data;
  logic       nack;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  logic       slave_sda;
  logic       stretch;

  // Open-drain bus: a line is high only when nobody pulls it low.
  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & slave_sda;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic       m_scl;
  logic       m_sda;
  logic [7:0] m_rd;
  logic       m_nack;

  typedef struct {
    logic [1:0] c;
    logic [7:0] data;
    logic       ack;
    logic [7:0] sbyte;
    logic       sack;
    int         st_bit;
    int         st_ticks;
    logic       exp_nack;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  ads_i2c_bit_engine #(.TICKS_PER_QUARTER(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mod_clk   (mod_clk),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .wr_data   (wr_data),
    .rd_ack    (rd_ack),
    .cmd_ready (cmd_ready),
    .done      (done),
    .rd_data   (rd_data),
    .nack      (nack),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int n_quarters(input logic [1:0] c);
    return (c == C_START || c == C_STOP) ? 4 : 36;
  endfunction

  function automatic logic slave_bit(input logic [1:0] c, input int b, input logic [7:0] sb,
                                     input logic sa);
    if (c == C_WRITE) return (b == 8) ? sa : 1'b1;
    if (c == C_READ)  return (b == 8) ? 1'b1 : sb[7-b];
    return 1'b1;
  endfunction

  // Line levels after quarter k of a command, straight from the quarter tables.
  task automatic apply_model(input logic [1:0] c, input logic [7:0] data, input logic ack,
                             input int k);
    int q;
    int b;
    q = k % 4;
    b = k / 4;
    case (c)
      C_START: case (q)
        0: m_sda = 1'b0;
        1: m_scl = 1'b0;
        2: m_sda = 1'b1;
        default: m_scl = 1'b1;
      endcase
      C_STOP: case (q)
        0: m_sda = 1'b1;
        1: m_scl = 1'b0;
        2: m_sda = 1'b0;
        default: ;
      endcase
      default: case (q)
        0: begin
          if (c == C_WRITE) m_sda = (b == 8) ? 1'b0 : ~data[7-b];
          else              m_sda = (b == 8) ? ack : 1'b0;
        end
        1: m_scl = 1'b0;
        2: ;
        default: m_scl = 1'b1;
      endcase
    endcase
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      mod_clk = ~mod_clk;
      @(posedge clk);
      #1;
      check("idle_scl", scl_oe, m_scl);
      check("idle_sda", sda_oe, m_sda);
      check("idle_ready", cmd_ready, 1);
      cyc(9);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] data, input logic ack,
                         input logic [7:0] sbyte, input logic sack, input int st_bit,
                         input int st_ticks, input bit tick_at_accept, input bit spam,
                         input int abort_k);
    int nq;
    int d0;
    int w;
    int q;
    int b;
    nq = n_quarters(c);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      cyc(1);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      check("ready_timeout", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd = c;
    wr_data = data;
    rd_ack = ack;
    if (tick_at_accept) mod_clk = ~mod_clk;
    @(posedge clk);
    #1;
    if (spam) begin
      cmd = ~c;
      wr_data = ~data;
      rd_ack = ~ack;
    end else begin
      cmd_valid = 1'b0;
    end
    check("ready_drop", cmd_ready, 0);
    d0 = done_seen;
    cyc(9);
    if (tick_at_accept) begin
      check("accept_tick_scl", scl_oe, m_scl);
      check("accept_tick_sda", sda_oe, m_sda);
    end
    for (int k = 0; k < nq; k++) begin
      q = k % 4;
      b = k / 4;
      slave_sda = slave_bit(c, b, sbyte, sack);
      if (q == 2 && b == st_bit) begin
        for (int s = 0; s < st_ticks; s++) begin
          stretch = 1'b1;
          mod_clk = ~mod_clk;
          @(posedge clk);
          #1;
          check("stretch_scl", scl_oe, m_scl);
          check("stretch_sda", sda_oe, m_sda);
          check("stretch_done", done, 0);
          cyc(9);
        end
      end
      stretch = 1'b0;
      if (k == abort_k) begin
        #5 reset = 1'b1;
        #1;
        check("abort_scl", scl_oe, 0);
        check("abort_sda", sda_oe, 0);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_scl = 1'b0;
        m_sda = 1'b0;
        m_rd = 8'h00;
        m_nack = 1'b0;
        cyc(3);
        check("abort_ready", cmd_ready, 1);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_rd_data", rd_data, m_rd);
        return;
      end
      if (spam && k == nq - 1) cmd_valid = 1'b0;
      apply_model(c, data, ack, k);
      mod_clk = ~mod_clk;
      @(posedge clk);
      #1;
      check("step_scl", scl_oe, m_scl);
      check("step_sda", sda_oe, m_sda);
      check("step_done", done, (k == nq - 1));
      if (c == C_READ && k == 20) check("rd_hold", rd_data, m_rd);
      if (k != nq - 1) cyc(9);
    end
    check("done_ready", cmd_ready, 1);
    cyc(1);
    check("done_width", done, 0);
    check("ready_stays", cmd_ready, 1);
    check("done_count", done_seen - d0, 1);
    if (c == C_WRITE) m_nack = sack;
    if (c == C_READ)  m_rd = sbyte;
    check("nack", nack, m_nack);
    check("rd_data", rd_data, m_rd);
    cyc(8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rc;
    vecs[0] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 8'h00};
    vecs[1] = '{C_WRITE, 8'h90, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 8'h00};
    vecs[2] = '{C_WRITE, 8'h90, 1'b0, 8'h00, 1'b1, -1, 0, 1'b1, 8'h00};
    vecs[3] = '{C_READ,  8'h00, 1'b0, 8'hA5, 1'b0, -1, 0, 1'b1, 8'hA5};
    vecs[4] = '{C_READ,  8'h00, 1'b1, 8'h3C, 1'b0, -1, 0, 1'b1, 8'h3C};
    vecs[5] = '{C_WRITE, 8'h5A, 1'b0, 8'h00, 1'b0,  3, 5, 1'b0, 8'h3C};
    vecs[6] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b0,  0, 2, 1'b0, 8'h3C};
    vecs[7] = '{C_STOP,  8'h00, 1'b0, 8'h00, 1'b0,  0, 1, 1'b0, 8'h3C};

    reset = 1'b1;
    mod_clk = 1'b0;
    cmd_valid = 1'b0;
    cmd = 2'b00;
    wr_data = 8'h00;
    rd_ack = 1'b0;
    slave_sda = 1'b1;
    stretch = 1'b0;
    m_scl = 1'b0;
    m_sda = 1'b0;
    m_rd = 8'h00;
    m_nack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl_oe, 0);
    check("rst_sda", sda_oe, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_nack", nack, 0);
    reset = 1'b0;
    cyc(3);
    idle_ticks(2);
    check("rst_no_done", done_seen, 0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].c, vecs[i].data, vecs[i].ack, vecs[i].sbyte, vecs[i].sack,
              vecs[i].st_bit, vecs[i].st_ticks, 1'b0, 1'b0, -1);
      check("vec_nack", nack, vecs[i].exp_nack);
      check("vec_rd_data", rd_data, vecs[i].exp_rd);
      check("vec_bus_scl", scl_oe, (vecs[i].c != C_STOP));
    end

    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? C_WRITE : C_READ;
      run_cmd(rc, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
              $urandom_range(0, 8), $urandom_range(0, 3), 1'b0, 1'b0, -1);
      idle_ticks($urandom_range(0, 2));
    end
    run_cmd(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 1'b0, -1);

    // A tick coinciding with the accept edge must not start the first quarter.
    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 1'b0, -1);
    run_cmd(C_WRITE, 8'h80, 1'b0, 8'h00, 1'b0, -1, 0, 1'b1, 1'b0, -1);
    // cmd_valid held high with other commands while busy.
    run_cmd(C_READ, 8'h00, 1'b1, 8'hC3, 1'b0, -1, 0, 1'b0, 1'b1, -1);
    // Async reset in bit 4 of a READ, then a clean START/STOP.
    run_cmd(C_READ, 8'h00, 1'b0, 8'h69, 1'b0, -1, 0, 1'b0, 1'b0, 16);
    run_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 1'b0, -1);
    run_cmd(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, 1'b0, 1'b0, -1);
    check("end_scl", scl_oe, 0);
    check("end_sda", sda_oe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
